// File: rtl/pu_msp430_per_timer_if.sv
// Peripheral bus bundle between the CPU memory backbone (master) and a peripheral (slave).
interface pu_msp430_per_timer_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/pu_msp430_per_timer.sv
// 16-bit interval timer on the peripheral bus: CTL/CNT/CMP/STAT, prescaled ticks, compare-match IRQ.
// Reads are combinational in the access cycle; writes take effect at the next mclk edge.
module pu_msp430_per_timer #(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic                        mclk,
  input  logic                        puc_rst,
  pu_msp430_per_timer_if.slave        bus,
  input  logic                        irq_acc,
  output logic                        irq_tmr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [11:0] BASE_HI = BASE_ADDR[14:3];

  state_t      state;
  logic        ctl_en, ctl_oneshot, ctl_ie;
  logic [1:0]  ctl_div;
  logic [15:0] cnt, cmp;
  logic        ifg;
  logic [2:0]  presc;

  logic        sel, wr, rd;
  logic [1:0]  reg_off;
  logic        ctl_wr, cnt_wr, cmp_wr, stat_wr;
  logic        tick, match, ifg_set, ifg_clr;
  logic [15:0] cnt_wdat, cmp_wdat, rd_dat;

  assign sel     = bus.per_en & (bus.per_addr[13:2] == BASE_HI);
  assign wr      = sel & (|bus.per_we);
  assign rd      = sel & ~(|bus.per_we);
  assign reg_off = bus.per_addr[1:0];

  assign ctl_wr  = wr & (reg_off == 2'd0);
  assign cnt_wr  = wr & (reg_off == 2'd1);
  assign cmp_wr  = wr & (reg_off == 2'd2);
  assign stat_wr = wr & (reg_off == 2'd3);

  assign cnt_wdat = {bus.per_we[1] ? bus.per_din[15:8] : cnt[15:8],
                     bus.per_we[0] ? bus.per_din[7:0]  : cnt[7:0]};
  assign cmp_wdat = {bus.per_we[1] ? bus.per_din[15:8] : cmp[15:8],
                     bus.per_we[0] ? bus.per_din[7:0]  : cmp[7:0]};

  always_comb begin
    tick = 1'b0;
    case (ctl_div)
      2'd0: tick = 1'b1;
      2'd1: tick = presc[0];
      2'd2: tick = &presc[1:0];
      2'd3: tick = &presc;
      default: tick = 1'b0;
    endcase
  end

  assign match   = (cnt == cmp);
  assign ifg_set = (state == RUN) & tick & match;
  // A match in the same cycle as a clear request keeps the flag set.
  assign ifg_clr = ((stat_wr & bus.per_we[0] & bus.per_din[0]) | irq_acc) & ~ifg_set;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state       <= IDLE;
      ctl_en      <= 1'b0;
      ctl_oneshot <= 1'b0;
      ctl_div     <= 2'd0;
      ctl_ie      <= 1'b0;
      cnt         <= 16'h0000;
      cmp         <= 16'hFFFF;
      ifg         <= 1'b0;
      presc       <= 3'd0;
      irq_tmr     <= 1'b0;
    end else begin
      irq_tmr <= ifg & ctl_ie;

      if (state == RUN) begin
        presc <= presc + 3'd1;
        if (tick) begin
          if (match) begin
            cnt <= 16'h0000;
            if (ctl_oneshot) begin
              ctl_en <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      end

      if (ifg_set)      ifg <= 1'b1;
      else if (ifg_clr) ifg <= 1'b0;

      // CPU writes are applied last so they override same-cycle tick updates.
      if (ctl_wr) begin
        presc <= 3'd0;
        if (bus.per_we[0]) begin
          ctl_en      <= bus.per_din[0];
          ctl_oneshot <= bus.per_din[1];
          ctl_div     <= bus.per_din[3:2];
          ctl_ie      <= bus.per_din[4];
          state       <= bus.per_din[0] ? RUN : IDLE;
        end
      end
      if (cnt_wr) begin
        cnt   <= cnt_wdat;
        presc <= 3'd0;
      end
      if (cmp_wr) cmp <= cmp_wdat;
    end
  end

  always_comb begin
    rd_dat = 16'h0000;
    if (rd) begin
      case (reg_off)
        2'd0:    rd_dat = {11'd0, ctl_ie, ctl_div, ctl_oneshot, ctl_en};
        2'd1:    rd_dat = cnt;
        2'd2:    rd_dat = cmp;
        default: rd_dat = {14'd0, (state == RUN), ifg};
      endcase
    end
  end

  assign bus.per_dout = rd_dat;

endmodule

// File: tb/tb_pu_msp430_per_timer.sv
// Directed bench for the peripheral timer: reset, counting, one-shot, byte writes, IFG priority, async reset.
module tb_pu_msp430_per_timer;

  localparam logic [14:0] BA   = 15'h0190;
  localparam logic [14:0] A_CTL  = BA;
  localparam logic [14:0] A_CNT  = BA + 15'd2;
  localparam logic [14:0] A_CMP  = BA + 15'd4;
  localparam logic [14:0] A_STAT = BA + 15'd6;
  localparam logic [14:0] A_OUT  = BA + 15'd8;

  logic mclk = 1'b0;
  logic puc_rst;
  logic irq_acc;
  logic irq_tmr;
  int   total = 0;
  int   bad   = 0;

  pu_msp430_per_timer_if bus_if ();

  pu_msp430_per_timer #(.BASE_ADDR(BA)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus_if),
    .irq_acc (irq_acc),
    .irq_tmr (irq_tmr)
  );

  always #5 mclk = ~mclk;

  // Bus drivers: called at a negedge; a write consumes one rising edge, a read none.
  task automatic bus_wr(input logic [14:0] addr, input logic [15:0] data, input logic [1:0] we);
    bus_if.per_addr = addr[14:1];
    bus_if.per_din  = data;
    bus_if.per_we   = we;
    bus_if.per_en   = 1'b1;
    @(negedge mclk);
    bus_if.per_en   = 1'b0;
    bus_if.per_we   = 2'b00;
  endtask

  task automatic bus_rd(input logic [14:0] addr, output logic [15:0] data);
    bus_if.per_addr = addr[14:1];
    bus_if.per_we   = 2'b00;
    bus_if.per_en   = 1'b1;
    #1;
    data = bus_if.per_dout;
    bus_if.per_en   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    puc_rst = 1'b1;
    irq_acc = 1'b0;
    bus_if.per_en = 1'b0; bus_if.per_we = 2'b00; bus_if.per_addr = '0; bus_if.per_din = '0;
    step(3);
    total++; if (irq_tmr !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_tmr); end
    puc_rst = 1'b0;
    step(1);
    bus_rd(A_CTL, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_ctl got=%h exp=0000", d); end
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", d); end
    bus_rd(A_CMP, d);
    total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL rst_cmp got=%h exp=FFFF", d); end
    step(1);
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_stat got=%h exp=0000", d); end
    bus_rd(A_OUT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL unsel_addr got=%h exp=0000", d); end
    bus_if.per_addr = A_CMP[14:1];
    #1;
    total++; if (bus_if.per_dout !== 16'h0000) begin bad++; $display("FAIL unsel_en got=%h exp=0000", bus_if.per_dout); end
    step(1);
  endtask

  task automatic test_byte_write;
    logic [15:0] d;
    bus_wr(A_CMP, 16'h12AB, 2'b10);
    bus_rd(A_CMP, d);
    total++; if (d !== 16'h12FF) begin bad++; $display("FAIL byte_hi got=%h exp=12FF", d); end
    bus_wr(A_CMP, 16'h0034, 2'b01);
    bus_rd(A_CMP, d);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL byte_lo got=%h exp=1234", d); end
    bus_wr(A_CTL, 16'hFFE0, 2'b11);
    bus_rd(A_CTL, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ctl_rsvd got=%h exp=0000", d); end
  endtask

  task automatic test_continuous;
    logic [15:0] d;
    bus_wr(A_CMP, 16'h0004, 2'b11);
    bus_wr(A_CTL, 16'h0011, 2'b11);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL cont_cnt0 got=%h exp=0000", d); end
    for (int i = 1; i <= 4; i++) begin
      step(1);
      bus_rd(A_CNT, d);
      total++; if (d !== 16'(i)) begin bad++; $display("FAIL cont_cnt%0d got=%h exp=%h", i, d, 16'(i)); end
    end
    step(1);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL cont_wrap got=%h exp=0000", d); end
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0003) begin bad++; $display("FAIL cont_stat got=%h exp=0003", d); end
    total++; if (irq_tmr !== 1'b0) begin bad++; $display("FAIL cont_irq_early got=%b exp=0", irq_tmr); end
    step(1);
    total++; if (irq_tmr !== 1'b1) begin bad++; $display("FAIL cont_irq got=%b exp=1", irq_tmr); end
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL cont_continue got=%h exp=0001", d); end
    bus_wr(A_CTL, 16'h0000, 2'b11);
    bus_wr(A_CNT, 16'h0000, 2'b11);
    bus_wr(A_STAT, 16'h0001, 2'b01);
  endtask

  task automatic test_oneshot;
    logic [15:0] d;
    bus_wr(A_CMP, 16'h0002, 2'b11);
    bus_wr(A_CTL, 16'h000F, 2'b11);
    step(7);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL os_presc got=%h exp=0000", d); end
    step(1);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL os_tick1 got=%h exp=0001", d); end
    step(8);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0002) begin bad++; $display("FAIL os_tick2 got=%h exp=0002", d); end
    step(8);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL os_match_cnt got=%h exp=0000", d); end
    bus_rd(A_CTL, d);
    total++; if (d !== 16'h000E) begin bad++; $display("FAIL os_ctl got=%h exp=000E", d); end
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL os_stat got=%h exp=0001", d); end
    step(50);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL os_hold got=%h exp=0000", d); end
    bus_wr(A_STAT, 16'h0001, 2'b01);
  endtask

  task automatic test_wrap;
    logic [15:0] d;
    bus_wr(A_CTL, 16'h0000, 2'b11);
    bus_wr(A_CNT, 16'hFFFE, 2'b11);
    bus_wr(A_CMP, 16'h0001, 2'b11);
    bus_wr(A_CTL, 16'h0001, 2'b11);
    step(1);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=FFFF", d); end
    step(1);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL wrap_0000 got=%h exp=0000", d); end
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0002) begin bad++; $display("FAIL wrap_noifg got=%h exp=0002", d); end
    step(2);
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0003) begin bad++; $display("FAIL wrap_match got=%h exp=0003", d); end
    bus_wr(A_CTL, 16'h0000, 2'b11);
    bus_wr(A_STAT, 16'h0001, 2'b01);
  endtask

  task automatic test_ifg_priority;
    logic [15:0] d;
    bus_wr(A_CNT, 16'h0000, 2'b11);
    bus_wr(A_CMP, 16'h0003, 2'b11);
    bus_wr(A_CTL, 16'h0011, 2'b11);
    step(3);
    irq_acc = 1'b1;
    bus_wr(A_STAT, 16'h0001, 2'b01);
    irq_acc = 1'b0;
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0003) begin bad++; $display("FAIL prio_ifg got=%h exp=0003", d); end
    total++; if (irq_tmr !== 1'b0) begin bad++; $display("FAIL prio_irq0 got=%b exp=0", irq_tmr); end
    bus_wr(A_STAT, 16'h0001, 2'b01);
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0002) begin bad++; $display("FAIL prio_w1c got=%h exp=0002", d); end
    total++; if (irq_tmr !== 1'b1) begin bad++; $display("FAIL prio_irq1 got=%b exp=1", irq_tmr); end
    step(1);
    total++; if (irq_tmr !== 1'b0) begin bad++; $display("FAIL prio_irq_clr got=%b exp=0", irq_tmr); end
  endtask

  task automatic test_async_reset;
    logic [15:0] d;
    bus_wr(A_CTL, 16'h0000, 2'b11);
    bus_wr(A_CNT, 16'h0000, 2'b11);
    bus_wr(A_CMP, 16'h0000, 2'b11);
    bus_wr(A_CTL, 16'h0011, 2'b11);
    step(2);
    total++; if (irq_tmr !== 1'b1) begin bad++; $display("FAIL cmp0_irq got=%b exp=1", irq_tmr); end
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL cmp0_cnt got=%h exp=0000", d); end
    bus_wr(A_CMP, 16'h0100, 2'b11);
    step(5);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0005) begin bad++; $display("FAIL ar_cnt5 got=%h exp=0005", d); end
    puc_rst = 1'b1;
    #1;
    total++; if (irq_tmr !== 1'b0) begin bad++; $display("FAIL ar_irq got=%b exp=0", irq_tmr); end
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ar_cnt got=%h exp=0000", d); end
    bus_rd(A_CMP, d);
    total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL ar_cmp got=%h exp=FFFF", d); end
    @(negedge mclk);
    bus_rd(A_CTL, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ar_ctl got=%h exp=0000", d); end
    puc_rst = 1'b0;
    step(10);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ar_hold got=%h exp=0000", d); end
    bus_rd(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ar_stat got=%h exp=0000", d); end
    step(1);
    bus_wr(A_CTL, 16'h0001, 2'b11);
    step(1);
    bus_rd(A_CNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL ar_restart got=%h exp=0001", d); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_continuous();
    test_oneshot();
    test_wrap();
    test_ifg_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
